// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
// Sequencer for an N-bit up/down count. A command (start, end, passes) is
// accepted over a valid/ready handshake; the count is then stepped one unit
// per cycle from start toward end, optionally ping-ponging between the two
// endpoints for the programmed number of traversals, and completion is
// flagged with a one-cycle pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (high only while idle)
//   cmd_start  first count value
//   cmd_end    first target value
//   cmd_passes endpoint-to-endpoint traversals (0 behaves as 1)
//   hold       freeze stepping while running
//   abort      terminate the running command
//   count      current count value
//   mode       current direction, 1 = up, 0 = down
//   busy       high while running
//   done       one-cycle pulse on normal completion
//   aborted    one-cycle pulse on abort
module updown_sweep_ctrl #(
  parameter int N = 4,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_end,
  input  logic [P-1:0] cmd_passes,
  input  logic         hold,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         mode,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [P-1:0] PASS_ONE = P'(1);

  state_t       state_reg;
  logic [N-1:0] count_reg;
  logic [N-1:0] tgt_reg;
  logic [N-1:0] oth_reg;
  logic [P-1:0] rem_reg;
  logic         dir_reg;
  logic         ready_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         aborted_reg;

  logic at_tgt;
  logic last_pass;

  assign at_tgt    = (count_reg == tgt_reg);
  // A degenerate sweep (both endpoints equal) finishes on its first
  // endpoint hit no matter how many passes were requested.
  assign last_pass = (rem_reg == PASS_ONE) || (tgt_reg == oth_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      tgt_reg     <= '0;
      oth_reg     <= '0;
      rem_reg     <= '0;
      dir_reg     <= 1'b1;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            count_reg <= cmd_start;
            tgt_reg   <= cmd_end;
            oth_reg   <= cmd_start;
            dir_reg   <= (cmd_end >= cmd_start);
            rem_reg   <= (cmd_passes == '0) ? PASS_ONE : cmd_passes;
            state_reg <= RUN;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else if (hold) begin
            // everything frozen
          end else if (at_tgt && last_pass) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (at_tgt) begin
            // Reverse and take the first step of the next pass in the same
            // edge, so the endpoint is shown for exactly one cycle.
            rem_reg   <= rem_reg - PASS_ONE;
            tgt_reg   <= oth_reg;
            oth_reg   <= tgt_reg;
            dir_reg   <= ~dir_reg;
            count_reg <= dir_reg ? (count_reg - CNT_ONE) : (count_reg + CNT_ONE);
          end else begin
            count_reg <= dir_reg ? (count_reg + CNT_ONE) : (count_reg - CNT_ONE);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign count     = count_reg;
  assign mode      = dir_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;

endmodule
